// File: rtl/ssd1306_cmd_ctrl_if.sv
// ssd1306_cmd_ctrl_if: groups the MCU-side OLED SPI pins and the framebuffer
// write port of the SSD1306 command controller.
// master: MCU / framebuffer side. slave: the controller itself.
interface ssd1306_cmd_ctrl_if;
    logic       ss_i;
    logic       scl_i;
    logic       mosi_i;
    logic       dc_i;
    logic       vram_we_o;
    logic [9:0] vram_addr_o;
    logic [7:0] vram_d_o;

    modport master (
        output ss_i, scl_i, mosi_i, dc_i,
        input  vram_we_o, vram_addr_o, vram_d_o
    );

    modport slave (
        input  ss_i, scl_i, mosi_i, dc_i,
        output vram_we_o, vram_addr_o, vram_d_o
    );
endinterface

// File: rtl/ssd1306_cmd_ctrl.sv
// ssd1306_cmd_ctrl: SPI-slave command decoder for an emulated SSD1306 OLED.
// Deserialises the MCU's OLED SPI stream, decodes commands into display
// configuration registers and produces auto-incrementing framebuffer writes.
// Optional feature macro: SSD1306_CTRL_PAGE_MODE_EN enables page addressing
// mode (reset mode becomes page) and the 0xB0-0xB7 / 0x00-0x1F opcodes.
module ssd1306_cmd_ctrl #(
    parameter int X_SIZE      = 128,
    parameter int PAGES       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ssd1306_cmd_ctrl_if.slave    bus,
    output logic                 disp_on_o,
    output logic                 invert_o,
    output logic [7:0]           contrast_o,
    output logic [5:0]           start_line_o,
    output logic                 cmd_busy_o
);
    localparam int CW = $clog2(X_SIZE);
    localparam int PW = $clog2(PAGES);
    localparam int L  = SYNC_STAGES - 1;
`ifdef SSD1306_CTRL_PAGE_MODE_EN
    localparam logic [1:0] RESET_MODE = 2'b10;
`else
    localparam logic [1:0] RESET_MODE = 2'b00;
`endif

    typedef enum logic [1:0] {IDLE, ARG, SKIP} state_t;

    logic [SYNC_STAGES-1:0] ss_sync, scl_sync, mosi_sync, dc_sync;
    logic                   scl_prev, ss_prev, shift_en;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic                   byte_valid, byte_dc;
    logic [7:0]             byte_data;

    state_t      state, state_next;
    logic [2:0]  arg_cnt, arg_cnt_next;
    logic [7:0]  op, op_next;
    logic [1:0]  mode, mode_next;
    logic [CW-1:0] col, col_next, col_start, col_start_next, col_end, col_end_next, col_inc;
    logic [PW-1:0] page, page_next, page_start, page_start_next, page_end, page_end_next, page_inc;
    logic        col_wrap, page_wrap;
    logic        disp_next, invert_next;
    logic [7:0]  contrast_next;
    logic [5:0]  start_next;
    logic        we_r, we_next;
    logic [9:0]  addr_r, addr_next, cur_addr;
    logic [7:0]  d_r, d_next;

    // Bring the asynchronous SPI pins into the clk_i domain and keep one extra sample of SCL/SS for edge detection.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ss_sync   <= '1;
            scl_sync  <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            scl_prev  <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_i};
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.dc_i};
            scl_prev  <= scl_sync[L];
            ss_prev   <= ss_sync[L];
        end
    end

    // SS is judged from the sample before the SCL rise, so SS rising together with the last SCL rise still accepts the byte.
    assign shift_en = scl_sync[L] & ~scl_prev & ~ss_prev;

    // Shift in MOSI MSB first; a full byte raises byte_valid for one cycle, partial bytes die when SS goes high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            byte_valid <= 1'b0;
            byte_dc    <= 1'b0;
            byte_data  <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            if (shift_en) begin
                shreg   <= {shreg[5:0], mosi_sync[L]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, mosi_sync[L]};
                    byte_dc    <= dc_sync[L];
                end
            end else if (ss_sync[L]) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    assign col_wrap  = (col == col_end);
    assign col_inc   = col_wrap ? col_start : ((col == CW'(X_SIZE - 1)) ? '0 : col + CW'(1));
    assign page_wrap = (page == page_end);
    assign page_inc  = page_wrap ? page_start : ((page == PW'(PAGES - 1)) ? '0 : page + PW'(1));
    assign cur_addr  = 10'(page) * 10'(X_SIZE) + 10'(col);

    // Command FSM and datapath next-state: data bytes write VRAM and advance the address, command bytes decode or consume arguments.
    always_comb begin
        state_next      = state;
        arg_cnt_next    = arg_cnt;
        op_next         = op;
        mode_next       = mode;
        col_next        = col;
        page_next       = page;
        col_start_next  = col_start;
        col_end_next    = col_end;
        page_start_next = page_start;
        page_end_next   = page_end;
        disp_next       = disp_on_o;
        invert_next     = invert_o;
        contrast_next   = contrast_o;
        start_next      = start_line_o;
        we_next         = 1'b0;
        addr_next       = addr_r;
        d_next          = d_r;
        if (byte_valid) begin
            if (byte_dc) begin
                we_next   = 1'b1;
                addr_next = cur_addr;
                d_next    = byte_data;
                if (mode == 2'b01) begin
                    page_next = page_inc;
                    if (page_wrap) col_next = col_inc;
                end
`ifdef SSD1306_CTRL_PAGE_MODE_EN
                else if (mode[1]) begin
                    col_next = col_inc;
                end
`endif
                else begin
                    col_next = col_inc;
                    if (col_wrap) page_next = page_inc;
                end
            end else if (state == IDLE) begin
                op_next = byte_data;
                if (byte_data[7:1] == 7'b1010111) disp_next = byte_data[0];
                else if (byte_data[7:1] == 7'b1010011) invert_next = byte_data[0];
                else if (byte_data[7:6] == 2'b01) start_next = byte_data[5:0];
`ifdef SSD1306_CTRL_PAGE_MODE_EN
                else if (mode[1] && byte_data[7:3] == 5'b10110) page_next = byte_data[PW-1:0];
                else if (mode[1] && byte_data[7:4] == 4'h0) col_next[3:0] = byte_data[3:0];
                else if (mode[1] && byte_data[7:4] == 4'h1) col_next[CW-1:4] = byte_data[CW-5:0];
`endif
                else begin
                    case (byte_data)
                        8'h81, 8'h20: begin state_next = ARG; arg_cnt_next = 3'd1; end
                        8'h21, 8'h22: begin state_next = ARG; arg_cnt_next = 3'd2; end
                        8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D:
                                      begin state_next = SKIP; arg_cnt_next = 3'd1; end
                        8'hA3:        begin state_next = SKIP; arg_cnt_next = 3'd2; end
                        8'h29, 8'h2A: begin state_next = SKIP; arg_cnt_next = 3'd5; end
                        8'h26, 8'h27: begin state_next = SKIP; arg_cnt_next = 3'd6; end
                        default: ;
                    endcase
                end
            end else begin
                arg_cnt_next = arg_cnt - 3'd1;
                if (arg_cnt == 3'd1) state_next = IDLE;
                if (state == ARG) begin
                    case (op)
                        8'h81: contrast_next = byte_data;
`ifdef SSD1306_CTRL_PAGE_MODE_EN
                        8'h20: mode_next = byte_data[1:0];
`else
                        8'h20: mode_next = (byte_data[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
                        8'h21: begin
                            if (arg_cnt == 3'd2) begin
                                col_start_next = byte_data[CW-1:0];
                                col_next       = byte_data[CW-1:0];
                            end else begin
                                col_end_next = byte_data[CW-1:0];
                            end
                        end
                        8'h22: begin
                            if (arg_cnt == 3'd2) begin
                                page_start_next = byte_data[PW-1:0];
                                page_next       = byte_data[PW-1:0];
                            end else begin
                                page_end_next = byte_data[PW-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // State register for the FSM, address pointers, ranges, configuration and VRAM port.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            arg_cnt      <= 3'd0;
            op           <= 8'd0;
            mode         <= RESET_MODE;
            col          <= '0;
            page         <= '0;
            col_start    <= '0;
            col_end      <= CW'(X_SIZE - 1);
            page_start   <= '0;
            page_end     <= PW'(PAGES - 1);
            disp_on_o    <= 1'b0;
            invert_o     <= 1'b0;
            contrast_o   <= 8'h7F;
            start_line_o <= 6'd0;
            we_r         <= 1'b0;
            addr_r       <= 10'd0;
            d_r          <= 8'd0;
        end else begin
            state        <= state_next;
            arg_cnt      <= arg_cnt_next;
            op           <= op_next;
            mode         <= mode_next;
            col          <= col_next;
            page         <= page_next;
            col_start    <= col_start_next;
            col_end      <= col_end_next;
            page_start   <= page_start_next;
            page_end     <= page_end_next;
            disp_on_o    <= disp_next;
            invert_o     <= invert_next;
            contrast_o   <= contrast_next;
            start_line_o <= start_next;
            we_r         <= we_next;
            addr_r       <= addr_next;
            d_r          <= d_next;
        end
    end

    assign cmd_busy_o      = (state != IDLE);
    assign bus.vram_we_o   = we_r;
    assign bus.vram_addr_o = addr_r;
    assign bus.vram_d_o    = d_r;
endmodule
